// File: rtl/raytrace_avm_pkg.sv
// Shared types and helpers for the raytracer Avalon-MM arbitration path.
package raytrace_avm_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 16;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [AW_DEF-1:0]     address;
        logic [DW_DEF-1:0]     writedata;
        logic [DW_DEF/8-1:0]   byteenable;
    } avm_cmd_t;

    // Width of a requester index; never zero, so two requesters still get one bit.
    function automatic int tagw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avm_tag_fifo.sv
// Synchronous FIFO holding the issuer index of each in-flight read beat.
module avm_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (pop_ok) begin
                rp <= rp + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/avm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among NREQ requesters,
// with a tag FIFO steering each read response back to its issuer.
module avm_rr_arbiter
    import raytrace_avm_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MAXPEND = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_read,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*AW-1:0]         req_address,
    input  logic [NREQ*DW-1:0]         req_writedata,
    input  logic [NREQ*DW/8-1:0]       req_byteenable,
    output logic [NREQ-1:0]            req_waitrequest,
    output logic [DW-1:0]              req_readdata,
    output logic [NREQ-1:0]            req_readdatavalid,
    output logic                       avm_m0_read,
    output logic                       avm_m0_write,
    output logic [AW-1:0]              avm_m0_address,
    output logic [DW-1:0]              avm_m0_writedata,
    output logic [DW/8-1:0]            avm_m0_byteenable,
    input  logic                       avm_m0_waitrequest,
    input  logic [DW-1:0]              avm_m0_readdata,
    input  logic                       avm_m0_readdatavalid,
    output logic [$clog2(MAXPEND):0]   pending,
    output logic                       err_orphan
);

    localparam int IW = tagw(NREQ);
    localparam int BW = DW / 8;

    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   lock_idx_q;
    logic            lock_q;
    logic [IW-1:0]   win;
    logic            grant_valid;
    logic [NREQ-1:0] eligible;
    logic            accept;
    logic            pop;
    logic            full;
    logic            empty;
    logic [IW-1:0]   head;
    int              idx;

    // A read cannot win while the tag FIFO is full, so a write elsewhere is not starved.
    always_comb begin
        win         = '0;
        grant_valid = 1'b0;
        idx         = 0;
        eligible    = req_write | (req_read & ~{NREQ{full}});
        if (!reset) begin
            if (lock_q) begin
                win         = lock_idx_q;
                grant_valid = 1'b1;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = int'(rr_q) + k;
                    if (idx >= NREQ) idx = idx - NREQ;
                    if (!grant_valid && eligible[idx]) begin
                        win         = IW'(idx);
                        grant_valid = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        avm_m0_read       = grant_valid & req_read[win] & ~full;
        avm_m0_write      = grant_valid & req_write[win];
        avm_m0_address    = grant_valid ? req_address[int'(win)*AW +: AW]     : '0;
        avm_m0_writedata  = grant_valid ? req_writedata[int'(win)*DW +: DW]   : '0;
        avm_m0_byteenable = grant_valid ? req_byteenable[int'(win)*BW +: BW]  : '0;
        for (int i = 0; i < NREQ; i++) begin
            req_waitrequest[i]   = reset | ~(grant_valid && int'(win) == i)
                                 | avm_m0_waitrequest | (req_read[i] & full);
            req_readdatavalid[i] = pop && int'(head) == i;
        end
    end

    assign accept       = (avm_m0_read | avm_m0_write) & ~avm_m0_waitrequest;
    assign pop          = avm_m0_readdatavalid & ~empty & ~reset;
    assign req_readdata = avm_m0_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (accept) begin
                lock_q <= 1'b0;
                rr_q   <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            end else if (avm_m0_read || avm_m0_write) begin
                lock_q     <= 1'b1;
                lock_idx_q <= win;
            end
            if (avm_m0_readdatavalid && empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    avm_tag_fifo #(
        .W     (IW),
        .DEPTH (MAXPEND)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept & avm_m0_read),
        .din   (win),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    assert property (@(posedge clk) disable iff (reset) (req_read & req_write) == '0);

endmodule

// File: tb/tb_avm_rr_arbiter.sv
// Directed bench for avm_rr_arbiter with a queue-based reference model checked every cycle.
module tb_avm_rr_arbiter;

    localparam int NREQ    = 2;
    localparam int AW      = 32;
    localparam int DW      = 16;
    localparam int BW      = DW / 8;
    localparam int MAXPEND = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NREQ-1:0]           req_read;
    logic [NREQ-1:0]           req_write;
    logic [NREQ*AW-1:0]        req_address;
    logic [NREQ*DW-1:0]        req_writedata;
    logic [NREQ*BW-1:0]        req_byteenable;
    logic [NREQ-1:0]           req_waitrequest;
    logic [DW-1:0]             req_readdata;
    logic [NREQ-1:0]           req_readdatavalid;
    logic                      avm_m0_read;
    logic                      avm_m0_write;
    logic [AW-1:0]             avm_m0_address;
    logic [DW-1:0]             avm_m0_writedata;
    logic [BW-1:0]             avm_m0_byteenable;
    logic                      avm_m0_waitrequest;
    logic [DW-1:0]             avm_m0_readdata;
    logic                      avm_m0_readdatavalid;
    logic [$clog2(MAXPEND):0]  pending;
    logic                      err_orphan;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    // Reference model state
    int m_rr   = 0;
    bit m_lock = 0;
    int m_lidx = 0;
    bit m_err  = 0;
    int tags[$];

    avm_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAXPEND(MAXPEND)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_read             (req_read),
        .req_write            (req_write),
        .req_address          (req_address),
        .req_writedata        (req_writedata),
        .req_byteenable       (req_byteenable),
        .req_waitrequest      (req_waitrequest),
        .req_readdata         (req_readdata),
        .req_readdatavalid    (req_readdatavalid),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .pending              (pending),
        .err_orphan           (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        if (reset) return -1;
        if (m_lock) return m_lidx;
        for (int k = 0; k < NREQ; k++) begin
            int r;
            r = (m_rr + k) % NREQ;
            if (req_write[r] || (req_read[r] && tags.size() < MAXPEND)) return r;
        end
        return -1;
    endfunction

    function automatic bit m_rd(input int g);
        return g >= 0 && req_read[g] && tags.size() < MAXPEND;
    endfunction

    function automatic bit m_wr(input int g);
        return g >= 0 && req_write[g];
    endfunction

    always @(posedge clk) begin
        int g;
        bit rd, wr, acc;
        if (reset) begin
            m_rr = 0; m_lock = 0; m_lidx = 0; m_err = 0;
            tags.delete();
        end else begin
            g   = m_grant();
            rd  = m_rd(g);
            wr  = m_wr(g);
            acc = (rd || wr) && !avm_m0_waitrequest;
            if (avm_m0_readdatavalid) begin
                if (tags.size() > 0) void'(tags.pop_front());
                else m_err = 1;
            end
            if (acc && rd) tags.push_back(g);
            if (acc) begin
                m_lock = 0;
                m_rr   = (g + 1) % NREQ;
            end else if (rd || wr) begin
                m_lock = 1;
                m_lidx = g;
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            int g;
            logic [NREQ-1:0] ew, ev;
            logic [AW-1:0]   ea;
            logic [DW-1:0]   ed;
            logic [BW-1:0]   eb;
            g  = m_grant();
            ea = (g >= 0) ? req_address[g*AW +: AW]    : '0;
            ed = (g >= 0) ? req_writedata[g*DW +: DW]  : '0;
            eb = (g >= 0) ? req_byteenable[g*BW +: BW] : '0;
            for (int i = 0; i < NREQ; i++) begin
                ew[i] = reset || i != g || avm_m0_waitrequest
                        || (req_read[i] && tags.size() >= MAXPEND);
                ev[i] = !reset && avm_m0_readdatavalid && tags.size() > 0 && tags[0] == i;
            end
            chk("m_read",    64'(avm_m0_read),       64'(m_rd(g)));
            chk("m_write",   64'(avm_m0_write),      64'(m_wr(g)));
            chk("m_addr",    64'(avm_m0_address),    64'(ea));
            chk("m_wdata",   64'(avm_m0_writedata),  64'(ed));
            chk("m_be",      64'(avm_m0_byteenable), 64'(eb));
            chk("m_wait",    64'(req_waitrequest),   64'(ew));
            chk("m_rdv",     64'(req_readdatavalid), 64'(ev));
            chk("m_rdata",   64'(req_readdata),      64'(avm_m0_readdata));
            chk("m_pending", 64'(pending),           64'(tags.size()));
            chk("m_orphan",  64'(err_orphan),        64'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BW-1:0] b);
        req_address[i*AW +: AW]    = a;
        req_writedata[i*DW +: DW]  = d;
        req_byteenable[i*BW +: BW] = b;
    endtask

    initial begin
        reset = 1'b1;
        req_read = 2'b11;
        req_write = 2'b00;
        req_address = '0;
        req_writedata = '0;
        req_byteenable = '0;
        avm_m0_waitrequest = 1'b0;
        avm_m0_readdata = '0;
        avm_m0_readdatavalid = 1'b0;
        set_req(0, 32'h10, 16'h0, 2'b11);
        set_req(1, 32'h20, 16'h0, 2'b11);

        // Reset held with requests active
        repeat (4) step();
        @(negedge clk);
        chk("rst_read",    64'(avm_m0_read),     64'd0);
        chk("rst_write",   64'(avm_m0_write),    64'd0);
        chk("rst_addr",    64'(avm_m0_address),  64'd0);
        chk("rst_wait",    64'(req_waitrequest), 64'b11);
        chk("rst_pending", 64'(pending),         64'd0);
        step();
        reset = 1'b0;
        req_read = 2'b00;

        // Single read and its response
        step();
        req_read = 2'b01;
        @(negedge clk);
        chk("rd_read", 64'(avm_m0_read),     64'd1);
        chk("rd_addr", 64'(avm_m0_address),  64'h10);
        chk("rd_wait", 64'(req_waitrequest), 64'b10);
        step();
        req_read = 2'b00;
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = 16'h000a;
        @(negedge clk);
        chk("rd_pending1", 64'(pending),           64'd1);
        chk("rd_rdv",      64'(req_readdatavalid), 64'b01);
        chk("rd_rdata",    64'(req_readdata),      64'h000a);
        step();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        chk("rd_pending0", 64'(pending), 64'd0);

        // Contention from a fresh pointer
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_read = 2'b11;
        set_req(0, 32'h100, 16'h0, 2'b11);
        set_req(1, 32'h200, 16'h0, 2'b11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_addr", 64'(avm_m0_address), (k % 2) ? 64'h200 : 64'h100);
            step();
        end
        req_read = 2'b00;
        @(negedge clk);
        chk("rr_pending", 64'(pending), 64'd4);
        for (int k = 0; k < 4; k++) begin
            step();
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata = 16'(k + 1);
            @(negedge clk);
            chk("rr_rdv", 64'(req_readdatavalid), (k % 2) ? 64'b10 : 64'b01);
        end
        step();
        avm_m0_readdatavalid = 1'b0;

        // Lock on a stalled requester 1
        req_read = 2'b10;
        avm_m0_waitrequest = 1'b1;
        @(negedge clk);
        chk("lk_addr0", 64'(avm_m0_address),  64'h200);
        chk("lk_wait0", 64'(req_waitrequest), 64'b11);
        step();
        req_read = 2'b11;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("lk_addr_hold", 64'(avm_m0_address), 64'h200);
            step();
        end
        avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        chk("lk_addr_acc", 64'(avm_m0_address),  64'h200);
        chk("lk_wait_acc", 64'(req_waitrequest), 64'b01);
        step();
        @(negedge clk);
        chk("lk_next", 64'(avm_m0_address), 64'h100);
        step();
        req_read = 2'b00;
        @(negedge clk);
        chk("lk_pending", 64'(pending), 64'd2);
        for (int k = 0; k < 2; k++) begin
            step();
            avm_m0_readdatavalid = 1'b1;
            @(negedge clk);
            chk("lk_rdv", 64'(req_readdatavalid), (k == 0) ? 64'b10 : 64'b01);
        end
        step();
        avm_m0_readdatavalid = 1'b0;

        // Full tag FIFO
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_read = 2'b01;
        set_req(0, 32'h400, 16'h0, 2'b11);
        repeat (8) step();
        @(negedge clk);
        chk("fl_pending8", 64'(pending),         64'd8);
        chk("fl_read",     64'(avm_m0_read),     64'd0);
        chk("fl_wait",     64'(req_waitrequest), 64'b11);
        step();
        req_write = 2'b10;
        set_req(1, 32'h300, 16'hbeef, 2'b11);
        @(negedge clk);
        chk("fl_wr",    64'(avm_m0_write),     64'd1);
        chk("fl_waddr", 64'(avm_m0_address),   64'h300);
        chk("fl_wdata", 64'(avm_m0_writedata), 64'hbeef);
        chk("fl_wrd",   64'(avm_m0_read),      64'd0);
        chk("fl_wwait", 64'(req_waitrequest),  64'b01);
        step();
        req_write = 2'b00;
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = 16'h0055;
        @(negedge clk);
        chk("fl_pop_read", 64'(avm_m0_read),       64'd0);
        chk("fl_pop_rdv",  64'(req_readdatavalid), 64'b01);
        step();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        chk("fl_free_read", 64'(avm_m0_read),    64'd1);
        chk("fl_free_addr", 64'(avm_m0_address), 64'h400);
        chk("fl_pending7",  64'(pending),        64'd7);
        step();
        req_read = 2'b00;
        @(negedge clk);
        chk("fl_refill", 64'(pending), 64'd8);
        avm_m0_readdatavalid = 1'b1;
        repeat (8) step();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        chk("fl_drained", 64'(pending), 64'd0);

        // Orphan responses
        chk("or_clear", 64'(err_orphan), 64'd0);
        step();
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = 16'h0077;
        @(negedge clk);
        chk("or_rdv", 64'(req_readdatavalid), 64'b00);
        step();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        chk("or_set", 64'(err_orphan), 64'd1);
        repeat (3) step();
        @(negedge clk);
        chk("or_sticky", 64'(err_orphan), 64'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("or_reset", 64'(err_orphan), 64'd0);
        step();
        req_read = 2'b01;
        step();
        req_read = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("or_flush", 64'(pending), 64'd0);
        step();
        avm_m0_readdatavalid = 1'b1;
        step();
        avm_m0_readdatavalid = 1'b0;
        @(negedge clk);
        chk("or_stale", 64'(err_orphan), 64'd1);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
